// File: rtl/hub75_scan_ctrl_pkg.sv
// Shared types and widths for the HUB75 scan sequencer and its
// fetch/shift engine interface.
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_SHIFT_WAIT = 3'd2,
        ST_DISP_WAIT  = 3'd3,
        ST_BLANK      = 3'd4,
        ST_LATCH      = 3'd5,
        ST_UNBLANK    = 3'd6,
        ST_DRAIN      = 3'd7
    } scan_state_t;

    localparam int TIMER_W = 24;
    localparam int BIT_W   = 3;
    localparam int ROW_W   = 8;
    localparam int PHASE_W = 4;

endpackage

// File: rtl/hub75_scan_ctrl_counter.sv
// Generic clearable up-counter; used as the BLANK/LATCH phase counter.
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 frame sequencer: walks rows and bit planes, overlaps shifting
// of the next plane with binary-weighted display of the current one.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int BITS    = 8,
    parameter int ROWS    = 32,
    parameter int ADDR_W  = 5,
    parameter int BASE_ON = 16,
    parameter int BLANK   = 2,
    parameter int LAT_W   = 1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              shift_busy,
    output logic              shift_start,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic [ROW_W-1:0]  row_cnt,
    output logic [ADDR_W-1:0] addr,
    output logic              lat,
    output logic              oe_n,
    output logic              frame_done
);

    localparam logic [PHASE_W-1:0] BLANK_LAST = PHASE_W'(BLANK - 1);
    localparam logic [PHASE_W-1:0] LAT_LAST   = PHASE_W'(LAT_W - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BITS - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [TIMER_W-1:0] ON_BASE    = TIMER_W'(BASE_ON);

    scan_state_t        r_state;
    logic               r_first;
    logic               r_start;
    logic [BIT_W-1:0]   r_bit;
    logic [ROW_W-1:0]   r_row;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_lat;
    logic               r_oe_n;
    logic               r_frame;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic [PHASE_W-1:0] w_phase;
    logic               w_in_phase;
    logic               w_phase_end;
    logic               w_phase_clr;

    assign w_in_phase  = (r_state == ST_BLANK) || (r_state == ST_LATCH);
    assign w_phase_end = ((r_state == ST_BLANK) && (w_phase == BLANK_LAST))
                      || ((r_state == ST_LATCH) && (w_phase == LAT_LAST));
    // Held clear outside the phases, so each phase starts counting at 0.
    assign w_phase_clr = !w_in_phase || w_phase_end;

    counter #(
        .WIDTH(PHASE_W)
    ) u_phase_cnt (
        .i_clk  (sys_clk),
        .i_rst  (rst),
        .i_clr  (w_phase_clr),
        .i_en   (w_in_phase),
        .o_count(w_phase)
    );

    always_comb begin
        w_timer_nxt = r_timer;
        if (r_state == ST_UNBLANK) begin
            w_timer_nxt = ON_BASE << r_bit;
        end else if (r_timer != '0) begin
            w_timer_nxt = r_timer - 1'b1;
        end
    end

    // oe_n tracks the next timer value so it is low exactly while the
    // registered timer is nonzero.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
            r_oe_n  <= 1'b1;
        end else begin
            r_timer <= w_timer_nxt;
            r_oe_n  <= (w_timer_nxt == '0);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_first <= 1'b0;
            r_start <= 1'b0;
            r_bit   <= '0;
            r_row   <= '0;
            r_addr  <= '0;
            r_lat   <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_frame <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_start <= 1'b1;
                    r_first <= 1'b1;
                    r_state <= ST_SHIFT_WAIT;
                end
                ST_SHIFT_WAIT: begin
                    // Engine raises busy a cycle late; skip the first look.
                    r_first <= 1'b0;
                    if (!r_first && !shift_busy) begin
                        r_state <= ST_DISP_WAIT;
                    end
                end
                ST_DISP_WAIT: begin
                    if (r_timer == '0) begin
                        r_state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (w_phase_end) begin
                        r_lat   <= 1'b1;
                        r_addr  <= r_row[ADDR_W-1:0];
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (w_phase_end) begin
                        r_lat   <= 1'b0;
                        r_frame <= (r_bit == BIT_LAST) && (r_row == ROW_LAST);
                        r_state <= ST_UNBLANK;
                    end
                end
                ST_UNBLANK: begin
                    if (r_bit == BIT_LAST) begin
                        r_bit <= '0;
                        if (r_row == ROW_LAST) begin
                            r_row <= '0;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_bit <= r_bit + 1'b1;
                    end
                    r_state <= enable ? ST_START : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (r_timer == '0) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign shift_start = r_start;
    assign bit_cnt     = r_bit;
    assign row_cnt     = r_row;
    assign addr        = r_addr;
    assign lat         = r_lat;
    assign oe_n        = r_oe_n;
    assign frame_done  = r_frame;

endmodule
